// File: rtl/jtpopeye_rom_arb.sv
// Three-slot ROM arbiter with one-word caches in front of a single SDRAM read port.
// Optional watchdog on stalled SDRAM transactions: define JTPOPEYE_ROMARB_TIMEOUT_EN.
module jtpopeye_rom_arb #(
    parameter int unsigned AW0  = 15,
    parameter int unsigned AW1  = 13,
    parameter int unsigned AW2  = 14,
    parameter logic [21:0] OFF1 = 22'h8000,
    parameter logic [21:0] OFF2 = 22'hA000,
    parameter int unsigned TOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           downloading,
    input  logic           slot0_cs,
    input  logic [AW0-1:0] slot0_addr,
    output logic [31:0]    slot0_dout,
    output logic           slot0_ok,
    input  logic           slot1_cs,
    input  logic [AW1-1:0] slot1_addr,
    output logic [31:0]    slot1_dout,
    output logic           slot1_ok,
    input  logic           slot2_cs,
    input  logic [AW2-1:0] slot2_addr,
    output logic [31:0]    slot2_dout,
    output logic           slot2_ok,
    output logic [21:0]    sdram_addr,
    output logic           sdram_req,
    input  logic           sdram_ack,
    input  logic [31:0]    data_read,
    input  logic           data_rdy,
    output logic           refresh_en,
    output logic           timeout
);

    localparam int unsigned AW01 = (AW0 > AW1) ? AW0 : AW1;
    localparam int unsigned AWM  = (AW01 > AW2) ? AW01 : AW2;

    if (TOUT == 0) begin : g_tout_chk
        $error("jtpopeye_rom_arb: TOUT must be nonzero");
    end

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY} state_t;

    state_t          state_q, state_d;
    logic [1:0]      slot_q, slot_d;
    logic [1:0]      last_q, last_d;
    logic [AWM-1:0]  addr_q, addr_d;
    logic [21:0]     sdram_addr_q, sdram_addr_d;
    logic            sdram_req_q, sdram_req_d;
    logic [2:0]      valid_q, valid_d;
    logic [AWM-1:0]  tag_q [3];
    logic [AWM-1:0]  tag_d [3];
    logic [31:0]     dout_q [3];
    logic [31:0]     dout_d [3];
    logic            timeout_q, timeout_d;

    logic [AWM-1:0]  req_addr [3];
    logic [21:0]     req_sdram [3];
    logic [2:0]      cs_v, hit, miss;
    logic            grant_vld;
    logic [1:0]      grant;
    logic            fill, expire, give_up;

    assign cs_v         = {slot2_cs, slot1_cs, slot0_cs};
    assign req_addr[0]  = AWM'(slot0_addr);
    assign req_addr[1]  = AWM'(slot1_addr);
    assign req_addr[2]  = AWM'(slot2_addr);
    assign req_sdram[0] = 22'(slot0_addr);
    assign req_sdram[1] = 22'(slot1_addr) + OFF1;
    assign req_sdram[2] = 22'(slot2_addr) + OFF2;

    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            hit[i]  = cs_v[i] & valid_q[i] & (tag_q[i] == req_addr[i]);
            miss[i] = cs_v[i] & ~hit[i];
        end
    end

    // Round-robin: search starts at the slot after the last one served.
    always_comb begin
        grant_vld = |miss;
        case (last_q)
            2'd0:    grant = miss[1] ? 2'd1 : (miss[2] ? 2'd2 : 2'd0);
            2'd1:    grant = miss[2] ? 2'd2 : (miss[0] ? 2'd0 : 2'd1);
            default: grant = miss[0] ? 2'd0 : (miss[1] ? 2'd1 : 2'd2);
        endcase
    end

    assign fill    = data_rdy & (((state_q == WAIT_ACK) & sdram_ack) | (state_q == WAIT_RDY));
    assign give_up = expire & ~fill;

`ifdef JTPOPEYE_ROMARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (state_q != IDLE) cnt_d = cnt_q + 1'b1;
    end

    assign expire = (state_q != IDLE) && (cnt_q == CW'(TOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || downloading) cnt_q <= '0;
        else                    cnt_q <= cnt_d;
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst || downloading) begin
            state_q      <= IDLE;
            slot_q       <= 2'd0;
            last_q       <= 2'd2;
            addr_q       <= '0;
            sdram_addr_q <= '0;
            sdram_req_q  <= 1'b0;
            valid_q      <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                tag_q[i]  <= '0;
                dout_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            last_q       <= last_d;
            addr_q       <= addr_d;
            sdram_addr_q <= sdram_addr_d;
            sdram_req_q  <= sdram_req_d;
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            dout_q       <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) timeout_q <= 1'b0;
        else     timeout_q <= timeout_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (grant_vld) state_d = WAIT_ACK;
            WAIT_ACK: begin
                if (fill || give_up) state_d = IDLE;
                else if (sdram_ack)  state_d = WAIT_RDY;
            end
            WAIT_RDY: if (fill || give_up) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        slot_d       = slot_q;
        last_d       = last_q;
        addr_d       = addr_q;
        sdram_addr_d = sdram_addr_q;
        sdram_req_d  = sdram_req_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        dout_d       = dout_q;
        timeout_d    = timeout_q;
        if (state_q == IDLE && grant_vld) begin
            slot_d       = grant;
            addr_d       = req_addr[grant];
            sdram_addr_d = req_sdram[grant];
            sdram_req_d  = 1'b1;
        end
        if (state_q == WAIT_ACK && sdram_ack) sdram_req_d = 1'b0;
        // Fill against the latched tag, so a requester that moved on still misses.
        if (fill) begin
            dout_d[slot_q]  = data_read;
            tag_d[slot_q]   = addr_q;
            valid_d[slot_q] = 1'b1;
            last_d          = slot_q;
            sdram_req_d     = 1'b0;
        end
        if (give_up) begin
            sdram_req_d = 1'b0;
            timeout_d   = 1'b1;
            last_d      = slot_q;
        end
    end

    assign slot0_dout = dout_q[0];
    assign slot1_dout = dout_q[1];
    assign slot2_dout = dout_q[2];
    assign slot0_ok   = hit[0];
    assign slot1_ok   = hit[1];
    assign slot2_ok   = hit[2];
    assign sdram_addr = sdram_addr_q;
    assign sdram_req  = sdram_req_q;
    assign refresh_en = (state_q == IDLE) && !(|miss);
    assign timeout    = timeout_q;

endmodule
